// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter sharing one single-cycle memory between an
// instruction-fetch port and a load/store data port. Data normally wins a
// conflict; a saturating starve counter forces fetch through after
// STARVE_LIMIT consecutive denied fetch cycles.
// Optional feature: define MEM_ARB_ALIGN_CHECK_EN to block misaligned or
// out-of-range (addr > 1020) accesses and raise the sticky align_err flag.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] addr,
    output logic [31:0] wd,
    input  logic [31:0] rd,
    output logic        align_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IFETCH  = 2'd1,
        DACCESS = 2'd2
    } state_t;

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    state_t     state;
    state_t     next_state;
    logic [2:0] starve_cnt;
    logic [2:0] next_starve_cnt;
    logic       i_grant;
    logic       d_grant;
    logic [31:0] sel_addr;
    logic       bad_addr;

    // Owner register and starve counter; reset abandons any access at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            starve_cnt <= 3'd0;
        end else begin
            state      <= next_state;
            starve_cnt <= next_starve_cnt;
        end
    end

    // Pick the next owner from this cycle's requests, data first unless fetch is starved.
    always_comb begin
        next_state = IDLE;
        if (i_req && d_req) begin
            next_state = (starve_cnt == LIMIT) ? IFETCH : DACCESS;
        end else if (i_req) begin
            next_state = IFETCH;
        end else if (d_req) begin
            next_state = DACCESS;
        end
    end

    // Count edges where fetch was waiting but lost, saturating at the limit.
    always_comb begin
        next_starve_cnt = starve_cnt;
        if (!i_req || next_state == IFETCH) begin
            next_starve_cnt = 3'd0;
        end else if (next_state == DACCESS && starve_cnt != LIMIT) begin
            next_starve_cnt = starve_cnt + 3'd1;
        end
    end

    // A grant is live only while the owner still holds its request.
    always_comb begin
        i_grant  = (state == IFETCH) && i_req;
        d_grant  = (state == DACCESS) && d_req;
        sel_addr = 32'd0;
        if (i_grant) begin
            sel_addr = i_addr;
        end else if (d_grant) begin
            sel_addr = d_addr;
        end
    end

`ifdef MEM_ARB_ALIGN_CHECK_EN
    assign bad_addr = (i_grant || d_grant) &&
                      ((sel_addr[1:0] != 2'b00) || (sel_addr > 32'd1020));

    // Sticky error flag, set by any blocked access and cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            align_err <= 1'b0;
        end else if (bad_addr) begin
            align_err <= 1'b1;
        end
    end
`else
    assign bad_addr  = 1'b0;
    assign align_err = 1'b0;
`endif

    // Steer the memory to the live owner; blocked accesses are acked with no effect.
    always_comb begin
        i_ack    = 1'b0;
        d_ack    = 1'b0;
        i_rdata  = 32'd0;
        d_rdata  = 32'd0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        wd       = 32'd0;
        addr     = sel_addr;
        if (i_grant) begin
            i_ack = 1'b1;
            if (!bad_addr) begin
                MemRead = 1'b1;
                i_rdata = rd;
            end
        end
        if (d_grant) begin
            d_ack = 1'b1;
            wd    = d_wdata;
            if (!bad_addr) begin
                MemRead  = ~d_we;
                MemWrite = d_we;
                if (!d_we) begin
                    d_rdata = rd;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a small word memory.
// Inputs change just after the falling edge; outputs are checked 1 time unit
// after the rising edge; the memory model commits stores at the falling edge.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        align_err;

    logic [31:0] mem [0:255];
    int          total = 0;
    int          bad = 0;
    int          wr_pulses = 0;
    int          p0;
    logic        exp_align;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .MemRead(MemRead), .MemWrite(MemWrite), .addr(addr), .wd(wd),
        .rd(rd), .align_err(align_err)
    );

    assign rd = mem[addr[9:2]];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic dr,
                                 input logic dw, input logic [31:0] da, input logic [31:0] dd);
        i_req   = ir;
        i_addr  = ia;
        d_req   = dr;
        d_we    = dw;
        d_addr  = da;
        d_wdata = dd;
    endtask

    task automatic nextEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic endCycle();
        @(negedge clk);
        checkBit("ack_exclusive", i_ack & d_ack, 1'b0);
        if (MemWrite) begin
            mem[addr[9:2]] = wd;
            wr_pulses++;
        end
        #1;
    endtask

    task automatic checkAllQuiet(input string tag);
        checkBit({tag, "_i_ack"}, i_ack, 1'b0);
        checkBit({tag, "_d_ack"}, d_ack, 1'b0);
        checkBit({tag, "_MemRead"}, MemRead, 1'b0);
        checkBit({tag, "_MemWrite"}, MemWrite, 1'b0);
        checkOutput({tag, "_addr"}, addr, 32'd0);
        checkOutput({tag, "_wd"}, wd, 32'd0);
        checkOutput({tag, "_i_rdata"}, i_rdata, 32'd0);
        checkOutput({tag, "_d_rdata"}, d_rdata, 32'd0);
    endtask

    initial begin
`ifdef MEM_ARB_ALIGN_CHECK_EN
        exp_align = 1'b1;
`else
        exp_align = 1'b0;
`endif
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[4]  = 32'h1234_5678;
        mem[16] = 32'hCAFE_F00D;

        // Reset held: outputs quiet even with both requests raised
        rst_n = 1'b0;
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        #2;
        checkAllQuiet("reset");
        checkBit("reset_align_err", align_err, 1'b0);
        applyStimulus(1'b1, 32'h10, 1'b1, 1'b0, 32'h40, 32'd0);
        nextEdge();
        checkAllQuiet("reset_req");
        endCycle();

        // Single fetch after release
        $display("[TB] single fetch");
        rst_n = 1'b1;
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'd0, 32'd0);
        nextEdge();
        checkBit("fetch_i_ack", i_ack, 1'b1);
        checkOutput("fetch_i_rdata", i_rdata, 32'h1234_5678);
        checkBit("fetch_MemRead", MemRead, 1'b1);
        checkBit("fetch_MemWrite", MemWrite, 1'b0);
        checkOutput("fetch_addr", addr, 32'h10);
        checkBit("fetch_d_ack", d_ack, 1'b0);
        i_req = 1'b0;
        #1;
        checkAllQuiet("fetch_dropped");
        endCycle();

        // Idle cycles
        $display("[TB] idle");
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int k = 0; k < 3; k++) begin
            nextEdge();
            checkAllQuiet("idle");
            checkOutput("idle_starve", {29'd0, dut.starve_cnt}, 32'd0);
            endCycle();
        end

        // Conflict: data wins four times, then starved fetch is forced
        $display("[TB] starvation");
        applyStimulus(1'b1, 32'h10, 1'b1, 1'b0, 32'h40, 32'd0);
        for (int k = 0; k < 4; k++) begin
            nextEdge();
            checkBit("starve_d_ack", d_ack, 1'b1);
            checkBit("starve_i_ack", i_ack, 1'b0);
            checkOutput("starve_d_rdata", d_rdata, 32'hCAFE_F00D);
            checkOutput("starve_i_rdata", i_rdata, 32'd0);
            checkOutput("starve_addr", addr, 32'h40);
            checkOutput("starve_cnt", {29'd0, dut.starve_cnt}, 32'(k + 1));
            endCycle();
        end
        nextEdge();
        checkBit("forced_i_ack", i_ack, 1'b1);
        checkBit("forced_d_ack", d_ack, 1'b0);
        checkOutput("forced_i_rdata", i_rdata, 32'h1234_5678);
        checkOutput("forced_d_rdata", d_rdata, 32'd0);
        checkOutput("forced_addr", addr, 32'h10);
        checkOutput("forced_cnt", {29'd0, dut.starve_cnt}, 32'd0);
        endCycle();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        nextEdge();
        endCycle();

        // Store then load back
        $display("[TB] store/load");
        p0 = wr_pulses;
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF);
        nextEdge();
        checkBit("store_d_ack", d_ack, 1'b1);
        checkBit("store_MemWrite", MemWrite, 1'b1);
        checkBit("store_MemRead", MemRead, 1'b0);
        checkOutput("store_addr", addr, 32'h20);
        checkOutput("store_wd", wd, 32'hDEAD_BEEF);
        checkOutput("store_d_rdata", d_rdata, 32'd0);
        endCycle();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        nextEdge();
        checkBit("store_after_MemWrite", MemWrite, 1'b0);
        checkBit("store_after_d_ack", d_ack, 1'b0);
        endCycle();
        checkOutput("store_pulses", 32'(wr_pulses - p0), 32'd1);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'h20, 32'd0);
        nextEdge();
        checkBit("load_d_ack", d_ack, 1'b1);
        checkOutput("load_d_rdata", d_rdata, 32'hDEAD_BEEF);
        checkBit("load_MemRead", MemRead, 1'b1);
        checkBit("load_MemWrite", MemWrite, 1'b0);
        endCycle();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        nextEdge();
        endCycle();

        // Reset in the middle of a store cycle
        $display("[TB] reset mid-store");
        p0 = wr_pulses;
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'h30, 32'hA5A5_A5A5);
        nextEdge();
        checkBit("midrst_pre_MemWrite", MemWrite, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkBit("midrst_MemWrite", MemWrite, 1'b0);
        checkBit("midrst_d_ack", d_ack, 1'b0);
        checkOutput("midrst_addr", addr, 32'd0);
        endCycle();
        nextEdge();
        checkBit("midrst_held_d_ack", d_ack, 1'b0);
        checkBit("midrst_held_MemWrite", MemWrite, 1'b0);
        endCycle();
        checkOutput("midrst_no_write", 32'(wr_pulses - p0), 32'd0);
        checkOutput("midrst_mem", mem[12], 32'd0);
        rst_n = 1'b1;
        #1;
        checkBit("release_no_ack", d_ack, 1'b0);
        nextEdge();
        checkBit("release_d_ack", d_ack, 1'b1);
        checkBit("release_MemWrite", MemWrite, 1'b1);
        endCycle();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        checkOutput("release_pulses", 32'(wr_pulses - p0), 32'd1);
        nextEdge();
        endCycle();

        // Misaligned load
        $display("[TB] misaligned load");
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'h22, 32'd0);
        nextEdge();
        checkBit("misal_d_ack", d_ack, 1'b1);
        checkBit("misal_MemRead", MemRead, ~exp_align);
        checkOutput("misal_d_rdata", d_rdata, exp_align ? 32'd0 : 32'hDEAD_BEEF);
        endCycle();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        nextEdge();
        checkBit("misal_align_err", align_err, exp_align);
        endCycle();
        nextEdge();
        checkBit("misal_align_err_sticky", align_err, exp_align);
        endCycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, legal 1..7: consecutive denied fetch-request cycles before fetch is forced to win.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_req  input  1  instruction-fetch read request; held high with i_addr stable until i_ack.
REQ-005 i_addr  input  32  fetch byte address.
REQ-006 i_ack  output  1  fetch access performed this cycle; i_rdata valid this cycle.
REQ-007 i_rdata  output  32  fetch read data.
REQ-008 d_req  input  1  data-port request; held high with d_we/d_addr/d_wdata stable until d_ack.
REQ-009 d_we  input  1  1 = store, 0 = load.
REQ-010 d_addr  input  32  data byte address.
REQ-011 d_wdata  input  32  store data.
REQ-012 d_ack  output  1  data access performed this cycle; d_rdata valid this cycle on loads.
REQ-013 d_rdata  output  32  load data.
REQ-014 MemRead, MemWrite  output  1 each  memory read/write enables.
REQ-015 addr, wd  output  32 each  memory byte address and write data.
REQ-016 rd  input  32  memory combinational read data.
REQ-017 align_err  output  1  sticky misalignment flag (see Configuration).

Function
REQ-018 FSM states SHALL be IDLE, IFETCH, DACCESS, held in a registered owner state; one access per granted cycle.
REQ-019 Arbitration SHALL occur at every rising edge from the current-cycle requests: neither requesting -> IDLE; one requesting -> that one; both -> DACCESS unless starve counter == STARVE_LIMIT, then IFETCH.
REQ-020 A request first sampled high at edge n SHALL be acked in cycle n+1 at the earliest (latency 1); ack SHALL be combinational from state and still-high req.
REQ-021 In IFETCH with i_req high: MemRead=1, MemWrite=0, addr=i_addr, i_rdata=rd, i_ack=1.
REQ-022 In DACCESS with d_req high: addr=d_addr, MemRead=~d_we, MemWrite=d_we, wd=d_wdata, d_rdata=rd on loads, d_ack=1.
REQ-023 In IDLE, or granted state whose req has dropped, MemRead=MemWrite=0, addr=wd=0, both acks 0, i_rdata=d_rdata=0.
REQ-024 Ungranted requester's ack and rdata SHALL be 0; both acks SHALL never be high together.
REQ-025 Back-to-back: a requester keeping req high after its ack SHALL be re-arbitrated next edge like a new request.
REQ-026 Starve counter (3 bits): increments, saturating at STARVE_LIMIT, on each edge where i_req=1 and DACCESS is chosen; clears when IFETCH is chosen or i_req=0.
REQ-027 MemWrite SHALL be high for exactly one cycle per acked store.

Reset
REQ-028 On rst_n low, immediately: state IDLE, starve counter 0, align_err 0, all outputs 0; a write in progress SHALL be abandoned with MemWrite dropping asynchronously.
REQ-029 First grant after reset release SHALL follow the first rising edge with rst_n high.

Configuration
REQ-030 Macro MEM_ARB_ALIGN_CHECK_EN defined: a granted access with addr[1:0]!=0 or addr>1020 SHALL be acked with MemRead=MemWrite=0, rdata 0, and SHALL set align_err until reset.
REQ-031 Macro undefined: no check, all accesses pass through, align_err tied 0.

Verification
REQ-032 Reset then i_req=1, i_addr=0x10, mem word 0x12345678 -> i_ack high one cycle later, i_rdata=0x12345678, MemWrite 0.
REQ-033 i_req and d_req (load 0x40) high together from same edge, STARVE_LIMIT=4 -> d_ack on 4 consecutive cycles, then i_ack on 5th, counter back to 0.
REQ-034 Store d_addr=0x20, d_wdata=0xDEADBEEF, then load 0x20 -> MemWrite high exactly one cycle, load returns 0xDEADBEEF.
REQ-035 rst_n pulled low mid-store cycle -> MemWrite and d_ack drop same instant, state IDLE, no ack until a new grant after release.
REQ-036 With MEM_ARB_ALIGN_CHECK_EN, load d_addr=0x22 -> d_ack high, MemRead 0, d_rdata 0, align_err 1 and stays 1; without the macro, MemRead 1 and align_err 0.
REQ-037 Both requests low all cycles -> IDLE held, all outputs 0, starve counter 0.
